// File: rtl/uart_bridge_pkg.sv
// -----------------------------------------------------------------------------
// uart_bridge_pkg
// Shared constants and types for the management UART register bridge.
//   OP_WRITE / OP_READ   : command opcodes (first byte of a frame)
//   RESP_ACK / RESP_NAK  : single-byte responses returned to the host
//   bridge_state_e       : command decoder state encoding
// -----------------------------------------------------------------------------
package uart_bridge_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS_WAIT,
    SEND,
    TX_GUARD
  } bridge_state_e;

  // True for the two opcodes that start a register access frame.
  function automatic logic is_command(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// -----------------------------------------------------------------------------
// timeout_counter
// Saturating up-counter used for the inter-byte frame timer and the bus
// acknowledge timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to zero (wins over run)
//   run        : count one clock; holds at LIMIT instead of wrapping
//   expired    : count has reached LIMIT
// -----------------------------------------------------------------------------
module timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int             W       = $clog2(LIMIT + 1);
  localparam logic [W-1:0]   LIMIT_V = W'(LIMIT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && (count_q != LIMIT_V)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT_V);

endmodule

// File: rtl/uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// uart_reg_bridge
// Decodes byte-framed commands from the UART receiver into 8-bit register
// accesses and returns one response byte per command to the UART transmitter.
//   write: 0x57, addr, data -> 0x06      read: 0x52, addr -> register value
//   anything else as first byte -> 0x15, missing ack -> 0x15
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_data, rx_en        : received byte and its one-cycle strobe
//   tx_data, tx_en        : response byte and its one-cycle strobe
//   tx_active             : UART transmitter busy
//   reg_addr, reg_wdata   : register address / write data (held between frames)
//   reg_wr, reg_rd        : one-cycle access requests
//   reg_rdata, reg_ack    : read data and completion strobe
//   rx_drop               : pulses when a byte arrives while a command is busy
// -----------------------------------------------------------------------------
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 2500000,
  parameter int BUS_TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_active,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack,
  output logic       rx_drop
);

  bridge_state_e state_q, state_d;
  logic          is_read_q, is_read_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    resp_q, resp_d;
  logic          reg_wr_q, reg_wr_d;
  logic          reg_rd_q, reg_rd_d;
  logic          rx_drop_q, rx_drop_d;

  logic in_frame;
  logic frame_expired;
  logic bus_clear, bus_run, bus_expired;

  // Frame timer restarts on every received byte and only counts while a
  // frame is partially assembled.
  assign in_frame = (state_q == GET_ADDR) || (state_q == GET_DATA);

  timeout_counter #(
    .LIMIT (FRAME_TIMEOUT)
  ) u_frame_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_en || !in_frame),
    .run     (in_frame),
    .expired (frame_expired)
  );

  // The bus timer starts counting on the edge that issues the request, so the
  // request cycle itself is the first waited clock and a missing ack produces
  // tx_en exactly BUS_TIMEOUT cycles after the request pulse.
  assign bus_run   = (state_d == BUS_WAIT);
  assign bus_clear = (state_q != BUS_WAIT) && (state_d != BUS_WAIT);

  timeout_counter #(
    .LIMIT (BUS_TIMEOUT)
  ) u_bus_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus_clear),
    .run     (bus_run),
    .expired (bus_expired)
  );

  // Next-state and output decode. tx_en is combinational from SEND so a
  // response goes out in the cycle after reg_ack when the UART is idle.
  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    resp_d    = resp_q;
    reg_wr_d  = 1'b0;
    reg_rd_d  = 1'b0;
    rx_drop_d = 1'b0;
    tx_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_en) begin
          is_read_d = (rx_data == OP_READ);
          if (is_command(rx_data)) begin
            state_d = GET_ADDR;
          end else begin
            resp_d  = RESP_NAK;
            state_d = SEND;
          end
        end
      end

      GET_ADDR: begin
        if (rx_en) begin
          addr_d = rx_data;
          if (is_read_q) begin
            reg_rd_d = 1'b1;
            state_d  = BUS_WAIT;
          end else begin
            state_d = GET_DATA;
          end
        end else if (frame_expired) begin
          state_d = IDLE;
        end
      end

      GET_DATA: begin
        if (rx_en) begin
          wdata_d  = rx_data;
          reg_wr_d = 1'b1;
          state_d  = BUS_WAIT;
        end else if (frame_expired) begin
          state_d = IDLE;
        end
      end

      // An ack in the same cycle the timer expires still counts as success.
      BUS_WAIT: begin
        rx_drop_d = rx_en;
        if (reg_ack) begin
          resp_d  = is_read_q ? reg_rdata : RESP_ACK;
          state_d = SEND;
        end else if (bus_expired) begin
          resp_d  = RESP_NAK;
          state_d = SEND;
        end
      end

      SEND: begin
        rx_drop_d = rx_en;
        if (!tx_active) begin
          tx_en   = 1'b1;
          state_d = TX_GUARD;
        end
      end

      // The UART only raises tx_active the cycle after tx_en, so this cycle
      // is spent without looking at it.
      TX_GUARD: begin
        rx_drop_d = rx_en;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_read_q <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      resp_q    <= 8'h00;
      reg_wr_q  <= 1'b0;
      reg_rd_q  <= 1'b0;
      rx_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      resp_q    <= resp_d;
      reg_wr_q  <= reg_wr_d;
      reg_rd_q  <= reg_rd_d;
      rx_drop_q <= rx_drop_d;
    end
  end

  assign tx_data   = resp_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_bridge
// Directed and randomized command frames against uart_reg_bridge. The bench
// plays the UART and a register slave; expected responses come from a
// register-file model updated from the commands the bench itself issues.
// -----------------------------------------------------------------------------
module tb_uart_reg_bridge;

  localparam int FRAME_TO = 100;
  localparam int BUS_TO   = 24;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_en;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_active;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       rx_drop;

  int checks = 0;
  int errors = 0;

  int wrCount   = 0;
  int rdCount   = 0;
  int txCount   = 0;
  int dropCount = 0;
  int bothCount = 0;

  logic [7:0] slaveMem [256];
  logic [7:0] modelMem [256];

  uart_reg_bridge #(
    .FRAME_TIMEOUT (FRAME_TO),
    .BUS_TIMEOUT   (BUS_TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_en     (rx_en),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_active (tx_active),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .rx_drop   (rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, used to catch missing, extra or
  // overlapping strobes.
  always @(negedge clk) begin
    if (reg_wr) wrCount <= wrCount + 1;
    if (reg_rd) rdCount <= rdCount + 1;
    if (tx_en) txCount <= txCount + 1;
    if (rx_drop) dropCount <= dropCount + 1;
    if (reg_wr && reg_rd) bothCount <= bothCount + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte from the UART receiver for exactly one clock.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data = b;
    rx_en   = 1'b1;
    @(posedge clk); #1;
    rx_en   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Count mid-cycle samples until tx_en is seen, bounded by limit.
  task automatic waitTx(input int limit, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!tx_en && (lat < limit));
  endtask

  // Issue a full command, act as the register slave, and check request
  // timing, request contents, response timing and response byte.
  // ackDelay < 0 means the slave never acknowledges.
  task automatic runCommand(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data,
                            input int ackDelay, input int gap, input string tag);
    bit         valid;
    bit         isRead;
    logic [7:0] expResp;
    int         lat;
    int         wr0, rd0, tx0;
    valid  = (op == 8'h57) || (op == 8'h52);
    isRead = (op == 8'h52);
    wr0 = wrCount;
    rd0 = rdCount;
    tx0 = txCount;
    applyStimulus(op);
    if (!valid) begin
      expResp = 8'h15;
      waitTx(4, lat);
      checkOutput({tag, ".nakLatency"}, lat, 1);
    end else begin
      idleCycles(gap);
      applyStimulus(addr);
      if (!isRead) begin
        idleCycles(gap);
        applyStimulus(data);
      end
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!(reg_rd || reg_wr) && (lat < 8));
      checkOutput({tag, ".reqLatency"}, lat, 1);
      checkOutput({tag, ".reqKind"}, {30'd0, reg_rd, reg_wr}, isRead ? 32'd2 : 32'd1);
      checkOutput({tag, ".reqAddr"}, reg_addr, addr);
      if (!isRead) checkOutput({tag, ".reqWdata"}, reg_wdata, data);
      if (ackDelay < 0) begin
        expResp = 8'h15;
        waitTx(BUS_TO + 8, lat);
        checkOutput({tag, ".timeoutLatency"}, lat, BUS_TO);
      end else begin
        idleCycles(ackDelay);
        reg_ack = 1'b1;
        if (isRead) begin
          reg_rdata = slaveMem[reg_addr];
          expResp   = modelMem[addr];
        end else begin
          slaveMem[reg_addr] = reg_wdata;
          reg_rdata          = 8'($urandom);
          modelMem[addr]     = data;
          expResp            = 8'h06;
        end
        @(posedge clk); #1;
        reg_ack   = 1'b0;
        reg_rdata = 8'h00;
        waitTx(4, lat);
        checkOutput({tag, ".ackLatency"}, lat, 1);
      end
    end
    checkOutput({tag, ".respByte"}, tx_data, expResp);
    idleCycles(2);
    checkOutput({tag, ".txPulses"}, txCount - tx0, 1);
    checkOutput({tag, ".wrPulses"}, wrCount - wr0, (valid && !isRead) ? 1 : 0);
    checkOutput({tag, ".rdPulses"}, rdCount - rd0, (valid && isRead) ? 1 : 0);
  endtask

  initial begin
    int         tx0, rd0, wr0;
    int         lat;
    int         k;
    int         rdel;
    logic [7:0] rop, raddr, rdat;

    rst_n     = 1'b0;
    rx_en     = 1'b0;
    rx_data   = 8'h00;
    tx_active = 1'b0;
    reg_rdata = 8'h00;
    reg_ack   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      slaveMem[i] = 8'(i * 7 + 3);
      modelMem[i] = 8'(i * 7 + 3);
    end
    slaveMem[8'h20] = 8'h3C;
    modelMem[8'h20] = 8'h3C;

    idleCycles(3);
    checkOutput("resetOutputs", {4'd0, tx_data, tx_en, reg_addr, reg_wdata, reg_wr, reg_rd, rx_drop}, 32'd0);
    rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] basic write/read/bad opcode");
    runCommand(8'h57, 8'h10, 8'hA5, 2, 0, "write");
    runCommand(8'h52, 8'h20, 8'h00, 3, 0, "read");
    runCommand(8'h52, 8'h10, 8'h00, 1, 0, "readBack");
    runCommand(8'hAA, 8'h00, 8'h00, 0, 0, "badOpcode");
    runCommand(8'h52, 8'h05, 8'h00, 2, 0, "readAfterNak");

    $display("[TB] frame timer");
    tx0 = txCount;
    rd0 = rdCount;
    wr0 = wrCount;
    applyStimulus(8'h57);
    idleCycles(FRAME_TO + 1);
    checkOutput("frameTo.noTx", txCount - tx0, 0);
    checkOutput("frameTo.noBus", (rdCount - rd0) + (wrCount - wr0), 0);
    runCommand(8'h52, 8'h01, 8'h00, 2, 0, "afterFrameTo");
    runCommand(8'h57, 8'h11, 8'h99, 1, FRAME_TO - 1, "slowFrame");
    runCommand(8'h52, 8'h11, 8'h00, 1, 0, "slowFrameReadBack");

    $display("[TB] bus timer");
    runCommand(8'h52, 8'h30, 8'h00, -1, 0, "busTimeout");
    runCommand(8'h57, 8'h31, 8'h42, -1, 0, "busTimeoutWr");
    runCommand(8'h52, 8'h40, 8'h00, BUS_TO - 1, 0, "ackAtLimit");

    $display("[TB] transmitter busy and dropped byte");
    applyStimulus(8'h52);
    applyStimulus(8'h44);
    @(negedge clk);
    checkOutput("stall.reqRd", reg_rd, 1'b1);
    @(posedge clk); #1;
    tx_active = 1'b1;
    reg_ack   = 1'b1;
    reg_rdata = slaveMem[reg_addr];
    @(posedge clk); #1;
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
    tx0 = txCount;
    idleCycles(10);
    applyStimulus(8'h57);
    @(negedge clk);
    checkOutput("stall.rxDrop", rx_drop, 1'b1);
    idleCycles(38);
    checkOutput("stall.noTx", txCount - tx0, 0);
    tx_active = 1'b0;
    @(negedge clk);
    checkOutput("stall.txEn", tx_en, 1'b1);
    checkOutput("stall.respByte", tx_data, modelMem[8'h44]);
    idleCycles(2);
    rd0 = rdCount;
    wr0 = wrCount;
    idleCycles(10);
    checkOutput("stall.droppedNoBus", (rdCount - rd0) + (wrCount - wr0), 0);
    runCommand(8'h52, 8'h44, 8'h00, 2, 0, "afterStall");

    $display("[TB] reset during bus wait");
    applyStimulus(8'h52);
    applyStimulus(8'h33);
    @(negedge clk);
    checkOutput("rst.reqRd", reg_rd, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.outputs", {4'd0, tx_data, tx_en, reg_addr, reg_wdata, reg_wr, reg_rd, rx_drop}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tx0 = txCount;
    rd0 = rdCount;
    wr0 = wrCount;
    reg_ack   = 1'b1;
    reg_rdata = 8'hEE;
    @(posedge clk); #1;
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
    idleCycles(BUS_TO + 10);
    checkOutput("rst.noTx", txCount - tx0, 0);
    checkOutput("rst.noBus", (rdCount - rd0) + (wrCount - wr0), 0);
    runCommand(8'h52, 8'h33, 8'h00, 1, 0, "afterReset");

    $display("[TB] randomized commands");
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 9);
      if (k < 4)      rop = 8'h57;
      else if (k < 8) rop = 8'h52;
      else            rop = 8'($urandom_range(0, 255));
      raddr = 8'($urandom_range(0, 255));
      rdat  = 8'($urandom_range(0, 255));
      rdel  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 6));
      runCommand(rop, raddr, rdat, rdel, 0, $sformatf("rand%0d", n));
    end

    idleCycles(2);
    checkOutput("neverWrAndRd", bothCount, 0);
    checkOutput("dropTotal", dropCount, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
